// File: rtl/gpu_cmd_pkg.sv
// Shared types and constants for the GPU command front-end.
// Covers the queued command payload, the register map and the dispatcher FSM states.
package gpu_cmd_pkg;

   localparam int unsigned NUM_V = 8;
   localparam int unsigned VW    = 16;

   localparam logic [3:0] OP_CRT       = 4'd0;
   localparam logic [3:0] OP_DEL       = 4'd1;
   localparam logic [3:0] OP_TRANS_ONE = 4'd3;
   localparam logic [3:0] OP_TRANS     = 4'd4;
   localparam logic [3:0] OP_SCALE     = 4'd5;
   localparam logic [3:0] OP_ROTL      = 4'd6;
   localparam logic [3:0] OP_ROTR      = 4'd7;

   localparam logic [3:0] ADDR_CMD     = 4'd8;
   localparam logic [3:0] ADDR_ATTR    = 4'd9;
   localparam logic [3:0] ADDR_OVF_CLR = 4'd15;

   // One queued geometry command, 151 bits
   typedef struct packed {
      logic [3:0]                  gmt_op;
      logic [3:0]                  gmt_code;
      logic [4:0]                  obj_num;
      logic [1:0]                  obj_type;
      logic [7:0]                  obj_color;
      logic [NUM_V-1:0][VW-1:0]    v;
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_ACK,
      ST_RUN
   } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO.
// A push against a full FIFO is still taken when a pop happens on the same edge.
module cmd_fifo
   import gpu_cmd_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  cmd_t                       wdata,
   output cmd_t                       rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   cmd_t            mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            wr_en;
   logic            rd_en;
   logic [CW-1:0]   count_nxt;

   assign wr_en     = push && (!full || pop);
   assign rd_en     = pop && !empty;
   assign count_nxt = count + CW'(wr_en) - CW'(rd_en);
   assign rdata     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/gpu_cmd_dispatcher.sv
// Register front-end and issue FSM feeding queued commands to matrix_unit.
// Staging registers are snapshotted into the FIFO on every command-word write.
module gpu_cmd_dispatcher
   import gpu_cmd_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned ACK_TIMEOUT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          reg_wr,
   input  logic [3:0]    reg_addr,
   input  logic [15:0]   reg_wdata,
   output logic          cmd_full,
   output logic          cmd_empty,
   output logic          cmd_ovf,
   output logic          idle,
   output logic [15:0]   v0,
   output logic [15:0]   v1,
   output logic [15:0]   v2,
   output logic [15:0]   v3,
   output logic [15:0]   v4,
   output logic [15:0]   v5,
   output logic [15:0]   v6,
   output logic [15:0]   v7,
   output logic [1:0]    obj_type,
   output logic [7:0]    obj_color,
   output logic [4:0]    obj_num_in,
   output logic [3:0]    gmt_op,
   output logic [3:0]    gmt_code,
   output logic          go,
   input  logic          busy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;

   logic [NUM_V-1:0][VW-1:0] stg_v;
   logic [1:0]               stg_type;
   logic [7:0]               stg_color;

   logic                     push;
   logic                     pop;
   cmd_t                     push_cmd;
   cmd_t                     head;
   cmd_t                     cur;
   logic [CW-1:0]            fifo_count;
   state_t                   state;
   logic [TW-1:0]            ack_cnt;

   assign push = reg_wr && (reg_addr == ADDR_CMD);
   assign pop  = (state == ST_IDLE) && (fifo_count != '0) && !busy;

   always_comb begin
      push_cmd           = '0;
      push_cmd.gmt_op    = reg_wdata[15:12];
      push_cmd.gmt_code  = reg_wdata[11:8];
      push_cmd.obj_num   = reg_wdata[4:0];
      push_cmd.obj_type  = stg_type;
      push_cmd.obj_color = stg_color;
      push_cmd.v         = stg_v;
   end

   // CPU staging registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_v     <= '0;
         stg_type  <= '0;
         stg_color <= '0;
      end else if (reg_wr) begin
         if (!reg_addr[3]) begin
            stg_v[reg_addr[2:0]] <= reg_wdata;
         end else if (reg_addr == ADDR_ATTR) begin
            stg_type  <= reg_wdata[9:8];
            stg_color <= reg_wdata[7:0];
         end
      end
   end

   // Drop flag: a new drop wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ovf <= 1'b0;
      end else if (push && cmd_full && !pop) begin
         cmd_ovf <= 1'b1;
      end else if (reg_wr && (reg_addr == ADDR_OVF_CLR)) begin
         cmd_ovf <= 1'b0;
      end
   end

   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (push_cmd),
      .rdata (head),
      .full  (cmd_full),
      .empty (cmd_empty),
      .count (fifo_count)
   );

   // Issue FSM; go is raised on the edge leaving ISSUE so it lines up with ACK
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         go      <= 1'b0;
         cur     <= '0;
         ack_cnt <= '0;
      end else begin
         go <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  cur   <= head;
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               go      <= 1'b1;
               ack_cnt <= '0;
               state   <= ST_ACK;
            end
            ST_ACK: begin
               if (busy) begin
                  state <= ST_RUN;
               end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
                  state <= ST_IDLE;
               end else begin
                  ack_cnt <= ack_cnt + TW'(1);
               end
            end
            ST_RUN: begin
               if (!busy) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign idle       = (state == ST_IDLE) && cmd_empty;
   assign v0         = cur.v[0];
   assign v1         = cur.v[1];
   assign v2         = cur.v[2];
   assign v3         = cur.v[3];
   assign v4         = cur.v[4];
   assign v5         = cur.v[5];
   assign v6         = cur.v[6];
   assign v7         = cur.v[7];
   assign obj_type   = cur.obj_type;
   assign obj_color  = cur.obj_color;
   assign obj_num_in = cur.obj_num;
   assign gmt_op     = cur.gmt_op;
   assign gmt_code   = cur.gmt_code;

endmodule

// File: tb/tb_gpu_cmd_dispatcher.sv
// Bench for gpu_cmd_dispatcher: directed phases plus random traffic checked
// against a queue of expected commands and a simple matrix_unit busy model.
module tb_gpu_cmd_dispatcher;
   import gpu_cmd_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned BW    = 151;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         reg_wr = 1'b0;
   logic [3:0]   reg_addr = '0;
   logic [15:0]  reg_wdata = '0;
   logic         cmd_full, cmd_empty, cmd_ovf, idle, go, busy;
   logic [15:0]  v0, v1, v2, v3, v4, v5, v6, v7;
   logic [1:0]   obj_type;
   logic [7:0]   obj_color;
   logic [4:0]   obj_num_in;
   logic [3:0]   gmt_op, gmt_code;

   int tests = 0;
   int fails = 0;

   // Reference model state
   cmd_t                      exp_q[$];
   logic [NUM_V-1:0][VW-1:0]  sh_v = '0;
   logic [1:0]                sh_type = '0;
   logic [7:0]                sh_color = '0;
   logic                      hold_busy = 1'b0;
   int                        busy_len = 0;
   int                        rem = 0;
   int                        go_cnt = 0;
   int                        cyc = 0;
   int                        last_go = -100;
   logic                      have = 1'b0;
   cmd_t                      snap;
   cmd_t                      obs;

   gpu_cmd_dispatcher #(.DEPTH(DEPTH), .ACK_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .cmd_full(cmd_full), .cmd_empty(cmd_empty), .cmd_ovf(cmd_ovf), .idle(idle),
      .v0(v0), .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6), .v7(v7),
      .obj_type(obj_type), .obj_color(obj_color), .obj_num_in(obj_num_in),
      .gmt_op(gmt_op), .gmt_code(gmt_code), .go(go), .busy(busy)
   );

   always #5 clk = ~clk;

   assign busy = hold_busy | (rem != 0);

   always_comb begin
      obs           = '0;
      obs.gmt_op    = gmt_op;
      obs.gmt_code  = gmt_code;
      obs.obj_num   = obj_num_in;
      obs.obj_type  = obj_type;
      obs.obj_color = obj_color;
      obs.v         = {v7, v6, v5, v4, v3, v2, v1, v0};
   end

   task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // matrix_unit model plus issue monitor: order, spacing, stability under busy
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         rem     = 0;
         have    = 1'b0;
         last_go = -100;
      end else begin
         if (rem != 0 && have) chk("hold_stable", BW'(obs), BW'(snap));
         if (go) begin
            go_cnt++;
            chk("go_spacing", BW'(cyc - last_go >= 4), BW'(1));
            last_go = cyc;
            chk("go_expected", BW'(exp_q.size() != 0), BW'(1));
            if (exp_q.size() != 0) begin
               chk("go_cmd", BW'(obs), BW'(exp_q[0]));
               void'(exp_q.pop_front());
            end
            snap = obs;
            have = 1'b1;
            rem  = busy_len;
         end else if (rem != 0) begin
            rem--;
         end
      end
   end

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      reg_wr    = 1'b1;
      reg_addr  = a;
      reg_wdata = d;
      if (a < 4'd8) sh_v[a[2:0]] = d;
      else if (a == ADDR_ATTR) begin
         sh_type  = d[9:8];
         sh_color = d[7:0];
      end
      @(negedge clk);
      reg_wr = 1'b0;
   endtask

   task automatic wr_cmd(input logic [15:0] d, input logic accept);
      cmd_t c;
      c.gmt_op    = d[15:12];
      c.gmt_code  = d[11:8];
      c.obj_num   = d[4:0];
      c.obj_type  = sh_type;
      c.obj_color = sh_color;
      c.v         = sh_v;
      if (accept) exp_q.push_back(c);
      wr(ADDR_CMD, d);
   endtask

   task automatic wait_go(input int max);
      int k = 0;
      while (!go && k < max) begin
         @(negedge clk);
         k++;
      end
      chk("wait_go", BW'(go), BW'(1));
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (!(idle && exp_q.size() == 0 && !busy) && k < max) begin
         @(negedge clk);
         k++;
      end
      chk("drain", BW'(idle && exp_q.size() == 0), BW'(1));
   endtask

   initial begin
      int g0;
      logic [15:0] tri_v [8];
      tri_v = '{16'd100, 16'd100, 16'd100, 16'd200, 16'd200, 16'd200, 16'd200, 16'd100};

      // Reset state
      #12;
      chk("rst_go", BW'(go), BW'(0));
      chk("rst_outputs", BW'(obs), BW'(0));
      chk("rst_status", BW'({cmd_empty, cmd_full, idle, cmd_ovf}), BW'(4'b1010));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single triangle create: go two edges after the push edge
      busy_len = 3;
      for (int i = 0; i < 8; i++) wr(4'(i), tri_v[i]);
      wr(ADDR_ATTR, 16'h0300);
      wr_cmd(16'h0000, 1'b1);
      chk("t1_go_n", BW'(go), BW'(0));
      chk("t1_empty_n", BW'(cmd_empty), BW'(0));
      @(negedge clk);
      chk("t1_go_n1", BW'(go), BW'(0));
      chk("t1_empty_n1", BW'(cmd_empty), BW'(1));
      @(negedge clk);
      chk("t1_go_n2", BW'(go), BW'(1));
      chk("t1_fields", BW'({gmt_op, obj_type, v3}), BW'({4'd0, 2'd3, 16'd200}));
      wait_idle(100);

      // Three queued commands, busy held 5 cycles each
      busy_len = 5;
      g0 = go_cnt;
      wr_cmd(16'h0000, 1'b1);
      wr(4'd0, 16'd300);
      wr_cmd(16'h4001, 1'b1);
      wr_cmd(16'h7A00, 1'b1);
      wait_idle(200);
      chk("three_issued", BW'(go_cnt - g0), BW'(3));

      // Busy already high in IDLE blocks pops; overflow on the 5th push
      hold_busy = 1'b1;
      @(negedge clk);
      g0 = go_cnt;
      for (int i = 0; i < 4; i++) wr_cmd(16'h1000 | 16'(i), 1'b1);
      chk("full_after4", BW'({cmd_full, cmd_ovf}), BW'(2'b10));
      wr_cmd(16'h1004, 1'b0);
      chk("ovf_set", BW'({cmd_full, cmd_ovf}), BW'(2'b11));
      wr(ADDR_OVF_CLR, 16'h0000);
      chk("ovf_clr", BW'(cmd_ovf), BW'(0));
      chk("no_pop_busy", BW'(go_cnt - g0), BW'(0));

      // Push into a full FIFO on the same edge as a pop
      hold_busy = 1'b0;
      busy_len  = 2;
      wr_cmd(16'h1105, 1'b1);
      chk("pushpop_full", BW'({cmd_full, cmd_ovf}), BW'(2'b10));
      wait_idle(300);
      chk("five_issued", BW'(go_cnt - g0), BW'(5));

      // busy never rises: ACK times out, back to IDLE four cycles after ACK entry
      busy_len = 0;
      wr_cmd(16'h3105, 1'b1);
      wait_go(20);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ack_wait", BW'(idle), BW'(0));
      end
      @(negedge clk);
      chk("ack_timeout_idle", BW'(idle), BW'(1));
      wr_cmd(16'h5207, 1'b1);
      wait_go(20);
      wait_idle(100);

      // Randomised traffic
      for (int it = 0; it < 60; it++) begin
         int op;
         op = int'($urandom_range(0, 4));
         if (op < 2) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 14));
            if (a == ADDR_CMD) a = 4'd10;
            wr(a, 16'($urandom));
         end else if (op < 4 && exp_q.size() < DEPTH) begin
            busy_len = int'($urandom_range(0, 6));
            wr_cmd(16'($urandom), 1'b1);
         end else begin
            @(negedge clk);
         end
      end
      wait_idle(1000);
      chk("rand_no_ovf", BW'(cmd_ovf), BW'(0));

      // Reset asserted while the op is in RUN with a command still queued
      busy_len = 10;
      wr_cmd(16'h6101, 1'b1);
      wr_cmd(16'h6202, 1'b1);
      wait_go(20);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      sh_v = '0;
      sh_type = '0;
      sh_color = '0;
      chk("midrst_go", BW'(go), BW'(0));
      chk("midrst_outputs", BW'(obs), BW'(0));
      chk("midrst_status", BW'({cmd_empty, cmd_full, idle, cmd_ovf}), BW'(4'b1010));
      @(negedge clk);
      #2 rst_n = 1'b1;
      g0 = go_cnt;
      for (int i = 0; i < 12; i++) @(negedge clk);
      chk("no_issue_after_rst", BW'(go_cnt - g0), BW'(0));
      chk("empty_after_rst", BW'(cmd_empty), BW'(1));

      // Staging cleared by reset
      busy_len = 1;
      wr_cmd(16'h5003, 1'b1);
      wait_idle(100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
